// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST master: state encoding, default widths
// and the pattern function used by both the pattern generator and the bench.
package ram_bist_pkg;

   localparam int DEF_ADDR_W = 1;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ERR_W  = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WR   = 2'd1;
   localparam logic [1:0] ST_RD   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Expected word for an address: seed + addr, optionally inverted.
   // Computed at 32 bits; callers truncate to their data width, which keeps
   // the mod 2**DATA_W wrap-around (inversion commutes with truncation).
   function automatic logic [31:0] pat(input logic [31:0] seed,
                                       input logic [31:0] addr,
                                       input logic        inv);
      logic [31:0] sum;
      sum = seed + addr;
      return inv ? ~sum : sum;
   endfunction

endpackage

// File: rtl/ram_bist_patgen.sv
// Combinational pattern generator: (seed, addr, pass_idx) -> expected word.
// Feeds both the write data and the read-back compare.
module ram_bist_patgen
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0] seed,
   input  logic [ADDR_W-1:0] addr,
   input  logic              inv,
   output logic [DATA_W-1:0] word
);

   assign word = DATA_W'(pat(32'(seed), 32'(addr), inv));

endmodule

// File: rtl/ram_bist_master.sv
// RAM BIST master: writes a seed-derived pattern to every address of one RAM,
// reads it back and compares, reporting busy/done/pass, first failing address
// and a saturating error count.
// Optional feature macro RAM_BIST_INV_PASS_EN: adds a second pass with the
// inverted pattern so every bit is exercised at both 0 and 1.
//
// state   | meaning
// ST_IDLE | after reset, waiting for start
// ST_WR   | writing pattern, one address per cycle
// ST_RD   | reading back and comparing, one address per cycle
// ST_DONE | results valid, waiting for the next start
module ram_bist_master
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ERR_W  = DEF_ERR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [DATA_W-1:0] seed,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] err_addr,
   output logic [ERR_W-1:0]  err_cnt
);

   logic [1:0]        state_q,    state_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [DATA_W-1:0] seed_q,     seed_d;
   logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic              inv;
   logic [DATA_W-1:0] exp_word;
   logic              last_addr;
   logic              mismatch;

`ifdef RAM_BIST_INV_PASS_EN
   logic              pass_idx_q, pass_idx_d;
   assign inv = pass_idx_q;
`else
   assign inv = 1'b0;
`endif

   ram_bist_patgen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_patgen (
      .seed (seed_q),
      .addr (addr_q),
      .inv  (inv),
      .word (exp_word)
   );

   assign last_addr = &addr_q;
   // Case inequality so X/Z on the read bus in simulation counts as a failure.
   assign mismatch  = (mem_rdata !== exp_word);

   // Next-state logic: sequencing, address counter, error capture.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      seed_d     = seed_q;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
`ifdef RAM_BIST_INV_PASS_EN
      pass_idx_d = pass_idx_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_WR;
               seed_d     = seed;
               addr_d     = '0;
               err_cnt_d  = '0;
               err_addr_d = '0;
`ifdef RAM_BIST_INV_PASS_EN
               pass_idx_d = 1'b0;
`endif
            end
         end
         ST_WR: begin
            addr_d = addr_q + ADDR_W'(1);
            if (last_addr) state_d = ST_RD;
         end
         ST_RD: begin
            addr_d = addr_q + ADDR_W'(1);
            if (mismatch) begin
               if (err_cnt_q == '0) err_addr_d = addr_q;
               if (err_cnt_q != '1) err_cnt_d  = err_cnt_q + ERR_W'(1);
            end
            if (last_addr) begin
`ifdef RAM_BIST_INV_PASS_EN
               if (!pass_idx_q) begin
                  state_d    = ST_WR;
                  pass_idx_d = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
`else
               state_d = ST_DONE;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         seed_q     <= '0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
`ifdef RAM_BIST_INV_PASS_EN
         pass_idx_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         seed_q     <= seed_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
`ifdef RAM_BIST_INV_PASS_EN
         pass_idx_q <= pass_idx_d;
`endif
      end
   end

   assign mem_rw    = (state_q == ST_WR);
   assign mem_addr  = addr_q;
   assign mem_wdata = mem_rw ? exp_word : '0;
   assign busy      = (state_q == ST_WR) || (state_q == ST_RD);
   assign done      = (state_q == ST_DONE);
   assign pass      = done && (err_cnt_q == '0);
   assign err_addr  = err_addr_q;
   assign err_cnt   = err_cnt_q;

endmodule
